// File: rtl/i2c_byte_ctrl.sv
// i2c_byte_ctrl: byte-level sequencer that turns one host transaction
// (optional START, byte write or read, ACK bit, optional STOP) into a
// series of single-bit cmd/cmd_ack handshakes on i2c_phy.
//
// Handshake: a phy command is held on phy_cmd/phy_din until phy_cmd_ack
// is seen high for one cycle; the next command (or NOP on finish/abort)
// is loaded on that same edge, so there is no NOP gap between commands.
module i2c_byte_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       req,
  input  logic       req_start,
  input  logic       req_stop,
  input  logic       req_write,
  input  logic       req_read,
  input  logic       ack_in,
  input  logic [7:0] txd,
  output logic       busy,
  output logic       done,
  output logic [7:0] rxd,
  output logic       rx_ack,
  output logic       al_out,
  output logic [3:0] phy_cmd,
  output logic       phy_din,
  input  logic       phy_cmd_ack,
  input  logic       phy_dout,
  input  logic       phy_al,
  output logic [2:0] dbg_state
);

  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_ACK   = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  state_t     r_state, w_state_nx, w_after;
  logic [3:0] r_phy_cmd, w_cmd_nx;
  logic       r_phy_din, w_din_nx;
  logic [7:0] r_sr, w_sr_nx;
  logic [2:0] r_cnt, w_cnt_nx;
  logic       r_busy, w_busy_nx;
  logic       r_done, w_done_nx;
  logic [7:0] r_rxd, w_rxd_nx;
  logic       r_rx_ack, w_rx_ack_nx;
  logic       r_al_out, w_al_nx;
  // Latched request flags; r_rd already has the write-wins rule applied.
  logic       r_stop, w_stop_nx;
  logic       r_wr, w_wr_nx;
  logic       r_rd, w_rd_nx;
  logic       r_ack_in, w_ack_in_nx;
  logic       w_adv;

  assign busy      = r_busy;
  assign done      = r_done;
  assign rxd       = r_rxd;
  assign rx_ack    = r_rx_ack;
  assign al_out    = r_al_out;
  assign phy_cmd   = r_phy_cmd;
  assign phy_din   = r_phy_din;
  assign dbg_state = r_state;

  // Next-state and next-output logic; w_adv/w_after select the state to
  // enter and the command it issues on the coming edge.
  always_comb begin
    w_state_nx  = r_state;
    w_cmd_nx    = r_phy_cmd;
    w_din_nx    = r_phy_din;
    w_sr_nx     = r_sr;
    w_cnt_nx    = r_cnt;
    w_busy_nx   = r_busy;
    w_done_nx   = 1'b0;
    w_rxd_nx    = r_rxd;
    w_rx_ack_nx = r_rx_ack;
    w_al_nx     = r_al_out;
    w_stop_nx   = r_stop;
    w_wr_nx     = r_wr;
    w_rd_nx     = r_rd;
    w_ack_in_nx = r_ack_in;
    w_adv       = 1'b0;
    w_after     = ST_IDLE;

    if ((r_state != ST_IDLE) && (phy_al || !ena)) begin
      // Abort: data registers hold, only control returns to idle.
      w_state_nx = ST_IDLE;
      w_cmd_nx   = CMD_NOP;
      w_cnt_nx   = 3'd7;
      w_busy_nx  = 1'b0;
      w_done_nx  = 1'b1;
      if (phy_al) w_al_nx = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req && ena) begin
            w_stop_nx   = req_stop;
            w_wr_nx     = req_write;
            w_rd_nx     = req_read & ~req_write;
            w_ack_in_nx = ack_in;
            w_sr_nx     = txd;
            w_al_nx     = 1'b0;
            w_busy_nx   = 1'b1;
            w_adv       = 1'b1;
            if (req_start)      w_after = ST_START;
            else if (req_write) w_after = ST_WRITE;
            else if (req_read)  w_after = ST_READ;
            else if (req_stop)  w_after = ST_STOP;
            else                w_after = ST_IDLE;
          end
        end
        ST_START: begin
          if (phy_cmd_ack) begin
            w_adv = 1'b1;
            if (r_wr)        w_after = ST_WRITE;
            else if (r_rd)   w_after = ST_READ;
            else if (r_stop) w_after = ST_STOP;
            else             w_after = ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (phy_cmd_ack) begin
            w_sr_nx = {r_sr[6:0], 1'b0};
            if (r_cnt == 3'd0) begin
              w_cnt_nx = 3'd7;
              w_adv    = 1'b1;
              w_after  = ST_ACK;
            end else begin
              w_cnt_nx = r_cnt - 3'd1;
              w_din_nx = r_sr[6];
            end
          end
        end
        ST_READ: begin
          if (phy_cmd_ack) begin
            w_rxd_nx = {r_rxd[6:0], phy_dout};
            if (r_cnt == 3'd0) begin
              w_cnt_nx = 3'd7;
              w_adv    = 1'b1;
              w_after  = ST_ACK;
            end else begin
              w_cnt_nx = r_cnt - 3'd1;
            end
          end
        end
        ST_ACK: begin
          if (phy_cmd_ack) begin
            if (r_wr) w_rx_ack_nx = phy_dout;
            w_adv   = 1'b1;
            w_after = r_stop ? ST_STOP : ST_IDLE;
          end
        end
        ST_STOP: begin
          if (phy_cmd_ack) begin
            w_adv   = 1'b1;
            w_after = ST_IDLE;
          end
        end
        default: begin
          w_adv   = 1'b1;
          w_after = ST_IDLE;
        end
      endcase

      if (w_adv) begin
        w_state_nx = w_after;
        case (w_after)
          ST_START: w_cmd_nx = CMD_START;
          ST_WRITE: begin
            w_cmd_nx = CMD_WRITE;
            w_din_nx = w_sr_nx[7];
          end
          ST_READ:  w_cmd_nx = CMD_READ;
          ST_ACK: begin
            if (r_wr) begin
              w_cmd_nx = CMD_READ;
            end else begin
              w_cmd_nx = CMD_WRITE;
              w_din_nx = r_ack_in;
            end
          end
          ST_STOP:  w_cmd_nx = CMD_STOP;
          default: begin
            w_cmd_nx  = CMD_NOP;
            w_busy_nx = 1'b0;
            w_done_nx = 1'b1;
          end
        endcase
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_phy_cmd <= CMD_NOP;
      r_phy_din <= 1'b0;
      r_sr      <= 8'h00;
      r_cnt     <= 3'd7;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rxd     <= 8'h00;
      r_rx_ack  <= 1'b0;
      r_al_out  <= 1'b0;
      r_stop    <= 1'b0;
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_ack_in  <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_phy_cmd <= w_cmd_nx;
      r_phy_din <= w_din_nx;
      r_sr      <= w_sr_nx;
      r_cnt     <= w_cnt_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
      r_rxd     <= w_rxd_nx;
      r_rx_ack  <= w_rx_ack_nx;
      r_al_out  <= w_al_nx;
      r_stop    <= w_stop_nx;
      r_wr      <= w_wr_nx;
      r_rd      <= w_rd_nx;
      r_ack_in  <= w_ack_in_nx;
    end
  end

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Bench for i2c_byte_ctrl: plays the phy, builds the expected command list
// of each transaction from the flags, and checks the sequence and results.
module tb_i2c_byte_ctrl;

  localparam logic [3:0] NOP   = 4'b0000;
  localparam logic [3:0] START = 4'b0001;
  localparam logic [3:0] STOP  = 4'b0010;
  localparam logic [3:0] WRITE = 4'b0100;
  localparam logic [3:0] READ  = 4'b1000;

  // role: 0 = plain command, 1 = data-bit read, 2 = slave ACK read
  typedef struct {
    logic [3:0] cmd;
    logic       din;
    bit         chk_din;
    logic       dout;
    int         role;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst, ena, req, req_start, req_stop, req_write, req_read, ack_in;
  logic [7:0] txd;
  logic       busy, done, rx_ack, al_out, phy_din;
  logic [7:0] rxd;
  logic [3:0] phy_cmd;
  logic       phy_cmd_ack, phy_dout, phy_al;
  logic [2:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // reference results carried across transactions
  logic [7:0] m_rxd;
  logic       m_rx_ack;
  logic       m_al;

  i2c_byte_ctrl dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req),
    .req_start(req_start), .req_stop(req_stop),
    .req_write(req_write), .req_read(req_read),
    .ack_in(ack_in), .txd(txd),
    .busy(busy), .done(done), .rxd(rxd), .rx_ack(rx_ack), .al_out(al_out),
    .phy_cmd(phy_cmd), .phy_din(phy_din),
    .phy_cmd_ack(phy_cmd_ack), .phy_dout(phy_dout), .phy_al(phy_al),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd"},    32'(phy_cmd), 32'(NOP));
    chk({tag, "_din"},    32'(phy_din), 0);
    chk({tag, "_busy"},   32'(busy),    0);
    chk({tag, "_done"},   32'(done),    0);
    chk({tag, "_rxd"},    32'(rxd),     0);
    chk({tag, "_rx_ack"}, 32'(rx_ack),  0);
    chk({tag, "_al"},     32'(al_out),  0);
  endtask

  // One host transaction. ab_idx selects the command during which an abort
  // is injected (ignored if out of range); ab_kind: 0 phy_al, 1 ena low,
  // 2 phy_al together with cmd_ack, 3 rst.
  task automatic run_txn(input bit s, input bit p, input bit w, input bit r,
                         input bit a, input logic [7:0] t, input logic [7:0] rb,
                         input bit sa, input int ab_idx, input int ab_kind,
                         input int mind, input int maxd);
    ent_t q[$];
    ent_t e;
    int   d;
    // expected command list from the transaction rules
    if (s) begin e = '{START, 1'b0, 1'b0, 1'b0, 0}; q.push_back(e); end
    if (w) begin
      for (int i = 7; i >= 0; i--) begin
        e = '{WRITE, t[i], 1'b1, 1'b0, 0}; q.push_back(e);
      end
      e = '{READ, 1'b0, 1'b0, sa, 2}; q.push_back(e);
    end else if (r) begin
      for (int i = 7; i >= 0; i--) begin
        e = '{READ, 1'b0, 1'b0, rb[i], 1}; q.push_back(e);
      end
      e = '{WRITE, a, 1'b1, 1'b0, 0}; q.push_back(e);
    end
    if (p) begin e = '{STOP, 1'b0, 1'b0, 1'b0, 0}; q.push_back(e); end

    req = 1'b1; req_start = s; req_stop = p; req_write = w; req_read = r;
    ack_in = a; txd = t;
    tick;
    req = 1'b0;
    // scramble request inputs to show they were latched
    req_start = 1'($urandom); req_stop = 1'($urandom); req_write = 1'($urandom);
    req_read = 1'($urandom); ack_in = 1'($urandom); txd = 8'($urandom);
    m_al = 1'b0;
    chk("accept_al", 32'(al_out), 0);
    if (q.size() == 0) begin
      chk("empty_done", 32'(done), 1);
      chk("empty_busy", 32'(busy), 0);
      chk("empty_cmd", 32'(phy_cmd), 32'(NOP));
      tick;
      chk("empty_done_end", 32'(done), 0);
      chk("empty_cmd_end", 32'(phy_cmd), 32'(NOP));
      return;
    end
    chk("accept_busy", 32'(busy), 1);

    for (int i = 0; i < q.size(); i++) begin
      d = $urandom_range(mind, maxd);
      for (int c = 0; c <= d; c++) begin
        chk("seq_cmd", 32'(phy_cmd), 32'(q[i].cmd));
        if (q[i].chk_din) chk("seq_din", 32'(phy_din), 32'(q[i].din));
        chk("seq_busy", 32'(busy), 1);
        chk("seq_done", 32'(done), 0);
        if (c < d) begin
          // requests while busy must be ignored
          if ($urandom_range(0, 2) == 0) begin
            req = 1'b1; req_start = 1'($urandom); req_write = 1'($urandom);
            req_read = 1'($urandom); req_stop = 1'($urandom);
          end
          tick;
          req = 1'b0;
        end
      end
      if (i == ab_idx) begin
        case (ab_kind)
          0: phy_al = 1'b1;
          1: ena = 1'b0;
          2: begin phy_al = 1'b1; phy_cmd_ack = 1'b1; phy_dout = ~q[i].dout; end
          default: rst = 1'b1;
        endcase
        tick;
        phy_al = 1'b0; ena = 1'b1; phy_cmd_ack = 1'b0; rst = 1'b0;
        if (ab_kind == 3) begin
          m_rxd = 8'h00; m_rx_ack = 1'b0; m_al = 1'b0;
          chk_reset_vals("rst_mid");
        end else begin
          m_al = (ab_kind != 1);
          chk("abort_done", 32'(done), 1);
          chk("abort_busy", 32'(busy), 0);
          chk("abort_cmd", 32'(phy_cmd), 32'(NOP));
          chk("abort_al", 32'(al_out), 32'(m_al));
          chk("abort_rxd", 32'(rxd), 32'(m_rxd));
          chk("abort_rx_ack", 32'(rx_ack), 32'(m_rx_ack));
        end
        tick;
        chk("abort_done_end", 32'(done), 0);
        chk("abort_idle_cmd", 32'(phy_cmd), 32'(NOP));
        chk("abort_al_hold", 32'(al_out), 32'(m_al));
        return;
      end
      phy_cmd_ack = 1'b1;
      phy_dout = q[i].dout;
      tick;
      phy_cmd_ack = 1'b0;
      phy_dout = 1'($urandom);
      if (q[i].role == 1) m_rxd = {m_rxd[6:0], q[i].dout};
      if (q[i].role == 2) m_rx_ack = q[i].dout;
      if (q[i].role == 1) chk("rxd_bitwise", 32'(rxd), 32'(m_rxd));
    end
    chk("fin_done", 32'(done), 1);
    chk("fin_busy", 32'(busy), 0);
    chk("fin_cmd", 32'(phy_cmd), 32'(NOP));
    chk("fin_rxd", 32'(rxd), 32'(m_rxd));
    chk("fin_rx_ack", 32'(rx_ack), 32'(m_rx_ack));
    chk("fin_al", 32'(al_out), 0);
    tick;
    chk("fin_done_end", 32'(done), 0);
  endtask

  initial begin
    int ab_idx, ab_kind;
    // reset
    rst = 1'b1; ena = 1'b1; req = 1'b0; req_start = 1'b0; req_stop = 1'b0;
    req_write = 1'b0; req_read = 1'b0; ack_in = 1'b0; txd = 8'h00;
    phy_cmd_ack = 1'b0; phy_dout = 1'b0; phy_al = 1'b0;
    m_rxd = 8'h00; m_rx_ack = 1'b0; m_al = 1'b0;
    tick; tick;
    rst = 1'b0;
    chk_reset_vals("reset");
    tick;
    chk_reset_vals("reset_hold");

    // stray cmd_ack in idle is ignored
    phy_cmd_ack = 1'b1; phy_dout = 1'b1;
    tick;
    phy_cmd_ack = 1'b0; phy_dout = 1'b0;
    chk_reset_vals("idle_ack");

    // START + write 0xA5 + STOP, slave ACKs
    run_txn(1, 1, 1, 0, 0, 8'hA5, 8'h00, 1'b0, -1, 0, 3, 3);
    // read 0x3C + NACK + STOP
    run_txn(0, 1, 0, 1, 1, 8'h00, 8'h3C, 1'b0, -1, 0, 3, 3);
    // arbitration lost on 4th write bit, then next request clears al_out
    run_txn(1, 1, 1, 0, 0, 8'h5A, 8'h00, 1'b0, 4, 0, 1, 2);
    run_txn(0, 0, 1, 0, 0, 8'hC3, 8'h00, 1'b1, -1, 0, 0, 2);
    // phy_al and cmd_ack together
    run_txn(1, 0, 1, 0, 0, 8'hF0, 8'h00, 1'b0, 3, 2, 1, 3);
    // ena dropped mid-read
    run_txn(1, 1, 0, 1, 0, 8'h00, 8'h96, 1'b0, 4, 1, 0, 2);
    // reset mid-read
    run_txn(0, 1, 0, 1, 1, 8'h00, 8'h69, 1'b0, 5, 3, 0, 2);
    // empty request
    run_txn(0, 0, 0, 0, 0, 8'h00, 8'h00, 1'b0, -1, 0, 0, 0);
    // write and read together: write wins
    run_txn(1, 1, 1, 1, 1, 8'h81, 8'hFF, 1'b1, -1, 0, 0, 1);
    // start + stop only
    run_txn(1, 1, 0, 0, 0, 8'h00, 8'h00, 1'b0, -1, 0, 0, 2);

    // randomized transactions
    for (int n = 0; n < 40; n++) begin
      ab_idx  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) : -1;
      ab_kind = $urandom_range(0, 3);
      run_txn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
              ab_idx, ab_kind, 0, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
